// File: rtl/shared_timer_arbiter_if.sv
// Request/response bundle between requesting FSMs and the shared timer arbiter.
// The master side drives requests; the slave side (the arbiter) returns accept, done and status.
interface shared_timer_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int COUNT_WIDTH = 8,
    parameter int ID_WIDTH    = 2
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*COUNT_WIDTH-1:0] req_count;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             done;
    logic                           busy;
    logic [ID_WIDTH-1:0]            active_id;
    logic [COUNT_WIDTH-1:0]         count_value;

    modport master (
        output req_valid, req_count,
        input  req_ready, done, busy, active_id, count_value
    );

    modport slave (
        input  req_valid, req_count,
        output req_ready, done, busy, active_id, count_value
    );
endinterface

// File: rtl/shared_timer_arbiter.sv
// One down-counter shared round-robin among NUM_REQ requesters; loads the winner's
// delay, counts to zero, then pulses that requester's done line for one cycle.
module shared_timer_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int COUNT_WIDTH = 8,
    parameter int ID_WIDTH    = 2
) (
    input logic                   clock,
    input logic                   reset,
    shared_timer_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state_r;
    logic [COUNT_WIDTH-1:0] counter_r;
    logic [ID_WIDTH-1:0]    active_id_r;
    logic [ID_WIDTH-1:0]    rr_ptr_r;
    logic [NUM_REQ-1:0]     done_r;
    logic                   busy_r;

    logic                   grant_found_s;
    logic [NUM_REQ-1:0]     grant_onehot_s;
    logic [ID_WIDTH-1:0]    grant_id_s;
    logic [ID_WIDTH-1:0]    next_ptr_s;
    logic [COUNT_WIDTH-1:0] grant_count_s;
    logic [NUM_REQ-1:0]     owner_onehot_s;
    logic [NUM_REQ-1:0]     req_ready_s;
    int                     rr_ptr_int_s;
    int                     dist_s;
    int                     best_dist_s;

    // Round-robin pick: the valid requester closest to rr_ptr (wrapping) wins.
    always_comb begin
        grant_found_s  = 1'b0;
        grant_onehot_s = '0;
        grant_id_s     = '0;
        next_ptr_s     = '0;
        grant_count_s  = '0;
        rr_ptr_int_s   = {{(32-ID_WIDTH){1'b0}}, rr_ptr_r};
        best_dist_s    = NUM_REQ;
        dist_s         = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            dist_s = (j >= rr_ptr_int_s) ? (j - rr_ptr_int_s) : (j + NUM_REQ - rr_ptr_int_s);
            if (bus.req_valid[j] && (dist_s < best_dist_s)) begin
                best_dist_s       = dist_s;
                grant_found_s     = 1'b1;
                grant_onehot_s    = '0;
                grant_onehot_s[j] = 1'b1;
                grant_id_s        = ID_WIDTH'(j);
                next_ptr_s        = (j == NUM_REQ - 1) ? '0 : ID_WIDTH'(j + 1);
                grant_count_s     = bus.req_count[j*COUNT_WIDTH +: COUNT_WIDTH];
            end else begin
                best_dist_s = best_dist_s;
            end
        end
    end

    // Accept is combinational and only offered from IDLE outside reset.
    always_comb begin
        req_ready_s = ((state_r == ST_IDLE) && !reset) ? grant_onehot_s : '0;
    end

    // One-hot decode of the current owner, used to build the done pulse.
    always_comb begin
        owner_onehot_s = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            owner_onehot_s[j] = (ID_WIDTH'(j) == active_id_r);
        end
    end

    // Main FSM; done and busy are registered alongside the state transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            counter_r   <= '0;
            active_id_r <= '0;
            rr_ptr_r    <= '0;
            done_r      <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= '0;
                    if (grant_found_s) begin
                        counter_r   <= grant_count_s;
                        active_id_r <= grant_id_s;
                        rr_ptr_r    <= next_ptr_s;
                        state_r     <= ST_COUNT;
                        busy_r      <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    // Zero is checked before decrementing, so the counter never wraps.
                    if (counter_r != '0) begin
                        counter_r <= counter_r - COUNT_WIDTH'(1);
                    end else begin
                        state_r <= ST_DONE;
                        done_r  <= owner_onehot_s;
                    end
                end
                ST_DONE: begin
                    done_r  <= '0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    counter_r <= '0;
                    done_r    <= '0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_s;
    assign bus.done        = done_r;
    assign bus.busy        = busy_r;
    assign bus.active_id   = active_id_r;
    assign bus.count_value = counter_r;

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Directed bench for shared_timer_arbiter: one task per scenario with inline checks
// against hand-computed cycle-by-cycle expectations.
module tb_shared_timer_arbiter;
    localparam int NR = 4;
    localparam int CW = 8;
    localparam int IW = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passes = 0;

    always #5 clock = ~clock;

    shared_timer_arbiter_if #(.NUM_REQ(NR), .COUNT_WIDTH(CW), .ID_WIDTH(IW)) bus ();

    shared_timer_arbiter #(.NUM_REQ(NR), .COUNT_WIDTH(CW), .ID_WIDTH(IW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_count(input int idx, input logic [CW-1:0] n);
        bus.req_count[idx*CW +: CW] = n;
    endtask

    task automatic do_reset();
        bus.req_valid = 4'b0000;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.req_valid = 4'b1111;
        bus.req_count = '0;
        reset = 1'b1;
        tick();
        checks++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready got %b exp 0000", bus.req_ready); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else passes++;
        checks++; if (bus.count_value !== 8'd0) $display("FAIL reset_count got %0d exp 0", bus.count_value); else passes++;
        checks++; if (bus.done !== 4'b0000) $display("FAIL reset_done got %b exp 0000", bus.done); else passes++;
        checks++; if (bus.active_id !== 2'd0) $display("FAIL reset_active_id got %0d exp 0", bus.active_id); else passes++;
        tick();
        bus.req_valid = 4'b0000;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_single();
        logic [7:0] exp_cnt;
        do_reset();
        set_count(0, 8'd3);
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) $display("FAIL single_ready got %b exp 0001", bus.req_ready); else passes++;
        tick();
        bus.req_valid = 4'b0000;
        checks++; if (bus.active_id !== 2'd0) $display("FAIL single_active_id got %0d exp 0", bus.active_id); else passes++;
        for (int k = 1; k <= 6; k++) begin
            exp_cnt = (k <= 4) ? 8'(4 - k) : 8'd0;
            checks++; if (bus.count_value !== exp_cnt) $display("FAIL single_count A+%0d got %0d exp %0d", k, bus.count_value, exp_cnt); else passes++;
            checks++; if (bus.done !== ((k == 5) ? 4'b0001 : 4'b0000)) $display("FAIL single_done A+%0d got %b", k, bus.done); else passes++;
            checks++; if (bus.busy !== (k <= 5)) $display("FAIL single_busy A+%0d got %b", k, bus.busy); else passes++;
            if (k < 6) tick();
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_oh;
        do_reset();
        for (int i = 0; i < NR; i++) set_count(i, 8'd1);
        bus.req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_oh = 4'b0001 << (g % 4);
            #1;
            checks++; if (bus.req_ready !== exp_oh) $display("FAIL rr_ready grant %0d got %b exp %b", g, bus.req_ready, exp_oh); else passes++;
            tick();
            checks++; if (bus.active_id !== 2'(g % 4)) $display("FAIL rr_active_id grant %0d got %0d exp %0d", g, bus.active_id, g % 4); else passes++;
            checks++; if (bus.req_ready !== 4'b0000) $display("FAIL rr_ready_busy grant %0d got %b exp 0000", g, bus.req_ready); else passes++;
            tick();
            checks++; if (bus.done !== 4'b0000) $display("FAIL rr_done_early grant %0d got %b exp 0000", g, bus.done); else passes++;
            tick();
            checks++; if (bus.done !== exp_oh) $display("FAIL rr_done grant %0d got %b exp %b", g, bus.done, exp_oh); else passes++;
            tick();
        end
        bus.req_valid = 4'b0000;
        #1;
    endtask

    task automatic test_zero_max();
        logic [7:0] exp_cnt;
        do_reset();
        set_count(2, 8'd0);
        bus.req_valid = 4'b0100;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) $display("FAIL zero_ready got %b exp 0100", bus.req_ready); else passes++;
        tick();
        bus.req_valid = 4'b0000;
        checks++; if (bus.done !== 4'b0000) $display("FAIL zero_done_early got %b exp 0000", bus.done); else passes++;
        checks++; if (bus.busy !== 1'b1) $display("FAIL zero_busy got %b exp 1", bus.busy); else passes++;
        tick();
        checks++; if (bus.done !== 4'b0100) $display("FAIL zero_done got %b exp 0100", bus.done); else passes++;
        tick();
        checks++; if (bus.busy !== 1'b0) $display("FAIL zero_idle_busy got %b exp 0", bus.busy); else passes++;

        set_count(2, 8'hFF);
        bus.req_valid = 4'b0100;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) $display("FAIL max_ready got %b exp 0100", bus.req_ready); else passes++;
        tick();
        bus.req_valid = 4'b0000;
        for (int k = 1; k <= 257; k++) begin
            exp_cnt = (k < 256) ? 8'(256 - k) : 8'd0;
            checks++; if (bus.count_value !== exp_cnt) $display("FAIL max_count A+%0d got %0d exp %0d", k, bus.count_value, exp_cnt); else passes++;
            checks++; if (bus.done !== ((k == 257) ? 4'b0100 : 4'b0000)) $display("FAIL max_done A+%0d got %b", k, bus.done); else passes++;
            if (k < 257) tick();
        end
        tick();
        checks++; if (bus.busy !== 1'b0) $display("FAIL max_idle_busy got %b exp 0", bus.busy); else passes++;
        checks++; if (bus.count_value !== 8'd0) $display("FAIL max_idle_count got %0d exp 0", bus.count_value); else passes++;
    endtask

    task automatic test_busy_request();
        do_reset();
        set_count(0, 8'd10);
        set_count(2, 8'd7);
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) $display("FAIL busyreq_ready0 got %b exp 0001", bus.req_ready); else passes++;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        tick();
        tick();
        bus.req_valid = 4'b0100;
        #1;
        for (int k = 4; k <= 12; k++) begin
            checks++; if (bus.req_ready !== 4'b0000) $display("FAIL busyreq_wait A+%0d got %b exp 0000", k, bus.req_ready); else passes++;
            if (k == 12) begin
                checks++; if (bus.done !== 4'b0001) $display("FAIL busyreq_done0 got %b exp 0001", bus.done); else passes++;
            end
            tick();
        end
        checks++; if (bus.req_ready !== 4'b0100) $display("FAIL busyreq_ready2 got %b exp 0100", bus.req_ready); else passes++;
        tick();
        bus.req_valid = 4'b0000;
        checks++; if (bus.active_id !== 2'd2) $display("FAIL busyreq_active_id got %0d exp 2", bus.active_id); else passes++;
        for (int c = 14; c <= 22; c++) begin
            checks++; if (bus.done !== ((c == 22) ? 4'b0100 : 4'b0000)) $display("FAIL busyreq_done2 A+%0d got %b", c, bus.done); else passes++;
            if (c < 22) tick();
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_count(1, 8'd20);
        bus.req_valid = 4'b0010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) $display("FAIL midrst_ready got %b exp 0010", bus.req_ready); else passes++;
        tick();
        bus.req_valid = 4'b0000;
        for (int k = 2; k <= 6; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", bus.busy); else passes++;
        checks++; if (bus.count_value !== 8'd0) $display("FAIL midrst_count got %0d exp 0", bus.count_value); else passes++;
        for (int c = 0; c < 30; c++) begin
            checks++; if (bus.done !== 4'b0000) $display("FAIL midrst_no_done cycle %0d got %b exp 0000", c, bus.done); else passes++;
            tick();
        end
        set_count(1, 8'd0);
        set_count(3, 8'd0);
        bus.req_valid = 4'b1010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) $display("FAIL midrst_rr_ptr got %b exp 0010", bus.req_ready); else passes++;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_valid_drop();
        set_count(3, 8'd5);
        bus.req_valid = 4'b1000;
        #1;
        checks++; if (bus.req_ready !== 4'b1000) $display("FAIL drop_ready got %b exp 1000", bus.req_ready); else passes++;
        tick();
        bus.req_valid = 4'b0000;
        for (int c = 1; c <= 7; c++) begin
            checks++; if (bus.done !== ((c == 7) ? 4'b1000 : 4'b0000)) $display("FAIL drop_done A+%0d got %b", c, bus.done); else passes++;
            if (c < 7) tick();
        end
        tick();
        checks++; if (bus.busy !== 1'b0) $display("FAIL drop_idle_busy got %b exp 0", bus.busy); else passes++;
    endtask

    initial begin
        bus.req_valid = 4'b0000;
        bus.req_count = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_max();
        test_busy_request();
        test_reset_mid();
        test_valid_drop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
